// File: rtl/uart_ram_loader.sv
// Receives a 'w' command followed by LOAD_BYTES bytes over the UART, writes them
// into the RAM as little-endian 16-bit words, then answers with an 8-bit checksum.
// Optional inter-byte timeout with 0xEE NAK: define LOADER_TIMEOUT_EN.
module uart_ram_loader #(
  parameter int LOAD_BYTES     = 16384,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_ready,
  input  logic [7:0]  uart_data_from_rx,
  input  logic        uart_tx_ready,
  output logic [7:0]  uart_data_to_tx,
  output logic        uart_tx_enable,
  output logic        ram_we,
  output logic [12:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic [15:0] ram_wmask
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    WAIT_CMD  = 3'd1,
    RECV_LO   = 3'd2,
    RECV_HI   = 3'd3,
    WRITE     = 3'd4,
    ACK_READY = 3'd5,
    ACK_SEND  = 3'd6,
    ACK_WAIT  = 3'd7
  } state_t;

  localparam logic [12:0] LAST_WORD = 13'(LOAD_BYTES / 2 - 1);
  localparam logic [7:0]  CMD_W     = 8'h77;
  localparam logic [7:0]  NAK_BYTE  = 8'hEE;

  state_t      state;
  logic [12:0] word_cnt;
  logic [7:0]  lo_byte;
  logic [7:0]  sum;
  logic [7:0]  tx_byte_reg;
  logic        tmo_hit;

  assign uart_data_to_tx = tx_byte_reg;
  assign ram_wmask       = 16'h0000;

  // Gated by rst so both strobes drop the instant reset is asserted.
  assign uart_tx_enable = !rst && ((state == INIT) || (state == ACK_SEND));
  assign ram_we         = !rst && (state == WRITE);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        nak;

  assign tmo_hit = ((state == RECV_LO) || (state == RECV_HI)) && !uart_rx_ready &&
                   (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Inter-byte silence counter, only meaningful while a load is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 32'd0;
    end else if (((state == RECV_LO) || (state == RECV_HI)) && !uart_rx_ready && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= 32'd0;
    end
  end

  // Remembers that the pending reply is a NAK rather than the checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nak <= 1'b0;
    end else if (tmo_hit) begin
      nak <= 1'b1;
    end else if (state == WAIT_CMD) begin
      nak <= 1'b0;
    end else begin
      nak <= nak;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Main load sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      word_cnt    <= 13'd0;
      lo_byte     <= 8'd0;
      sum         <= 8'd0;
      tx_byte_reg <= 8'd0;
      ram_waddr   <= 13'd0;
      ram_wdata   <= 16'd0;
    end else begin
      case (state)
        INIT: begin
          tx_byte_reg <= 8'd0;
          state       <= WAIT_CMD;
        end
        WAIT_CMD: begin
          if (uart_rx_ready && (uart_data_from_rx == CMD_W)) begin
            word_cnt <= 13'd0;
            sum      <= 8'd0;
            state    <= RECV_LO;
          end
        end
        RECV_LO: begin
          if (uart_rx_ready) begin
            lo_byte <= uart_data_from_rx;
            sum     <= sum + uart_data_from_rx;
            state   <= RECV_HI;
          end else if (tmo_hit) begin
            tx_byte_reg <= NAK_BYTE;
            state       <= ACK_READY;
          end
        end
        RECV_HI: begin
          if (uart_rx_ready) begin
            ram_wdata <= {uart_data_from_rx, lo_byte};
            ram_waddr <= word_cnt;
            sum       <= sum + uart_data_from_rx;
            state     <= WRITE;
          end else if (tmo_hit) begin
            tx_byte_reg <= NAK_BYTE;
            state       <= ACK_READY;
          end
        end
        WRITE: begin
          // word_cnt stops at the last address, so it can never wrap.
          if (word_cnt == LAST_WORD) begin
            state <= ACK_READY;
          end else begin
            word_cnt <= word_cnt + 13'd1;
            state    <= RECV_LO;
          end
        end
        ACK_READY: begin
`ifdef LOADER_TIMEOUT_EN
          tx_byte_reg <= nak ? NAK_BYTE : sum;
`else
          tx_byte_reg <= sum;
`endif
          if (uart_tx_ready) begin
            state <= ACK_SEND;
          end
        end
        ACK_SEND: begin
          state <= ACK_WAIT;
        end
        ACK_WAIT: begin
          if (uart_tx_ready) begin
            state <= WAIT_CMD;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench: a LOAD_BYTES=4 instance for protocol details and a default-size
// instance for the full 16 KiB load.
module tb_uart_ram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s, rx_rdy_s, tx_rdy_s;
  logic [7:0]  rx_d_s, tx_d_s;
  logic        tx_en_s, we_s;
  logic [12:0] waddr_s;
  logic [15:0] wdata_s, wmask_s;

  logic        rst_l, rx_rdy_l, tx_rdy_l;
  logic [7:0]  rx_d_l, tx_d_l;
  logic        tx_en_l, we_l;
  logic [12:0] waddr_l;
  logic [15:0] wdata_l, wmask_l;

  uart_ram_loader #(.LOAD_BYTES(4), .TIMEOUT_CYCLES(100)) dut_s (
    .clk(clk), .rst(rst_s), .uart_rx_ready(rx_rdy_s), .uart_data_from_rx(rx_d_s),
    .uart_tx_ready(tx_rdy_s), .uart_data_to_tx(tx_d_s), .uart_tx_enable(tx_en_s),
    .ram_we(we_s), .ram_waddr(waddr_s), .ram_wdata(wdata_s), .ram_wmask(wmask_s)
  );

  uart_ram_loader dut_l (
    .clk(clk), .rst(rst_l), .uart_rx_ready(rx_rdy_l), .uart_data_from_rx(rx_d_l),
    .uart_tx_ready(tx_rdy_l), .uart_data_to_tx(tx_d_l), .uart_tx_enable(tx_en_l),
    .ram_we(we_l), .ram_waddr(waddr_l), .ram_wdata(wdata_l), .ram_wmask(wmask_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [12:0] s_addr_q[$];
  logic [15:0] s_data_q[$];
  logic [7:0]  s_tx_q[$];

  // Record every write and every transmitted byte of the small instance.
  always @(negedge clk) begin
    if (!rst_s) begin
      if (we_s) begin
        s_addr_q.push_back(waddr_s);
        s_data_q.push_back(wdata_s);
        check_eq("s_wmask", 32'(wmask_s), 32'h0);
      end
      if (tx_en_s) s_tx_q.push_back(tx_d_s);
    end
  end

  int          l_we_cnt = 0;
  int          l_tx_cnt = 0;
  logic [7:0]  l_tx_last = 8'h00;
  logic [12:0] l_exp_addr = 13'd0;

  // Large instance: addresses must advance strictly in order, data all ones.
  always @(negedge clk) begin
    if (!rst_l) begin
      if (we_l) begin
        check_eq("l_addr", 32'(waddr_l), 32'(l_exp_addr));
        check_eq("l_data", 32'(wdata_l), 32'h0000FFFF);
        check_eq("l_wmask", 32'(wmask_l), 32'h0);
        l_exp_addr = l_exp_addr + 13'd1;
        l_we_cnt++;
      end
      if (tx_en_l) begin
        l_tx_cnt++;
        l_tx_last = tx_d_l;
      end
    end
  end

  task automatic pulse_s(input logic [7:0] b);
    @(posedge clk); #1;
    rx_d_s = b; rx_rdy_s = 1'b1;
    @(posedge clk); #1;
    rx_rdy_s = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] b);
    pulse_s(b);
    repeat (2) @(posedge clk);
  endtask

  task automatic send_l(input logic [7:0] b);
    @(posedge clk); #1;
    rx_d_l = b; rx_rdy_l = 1'b1;
    @(posedge clk); #1;
    rx_rdy_l = 1'b0;
  endtask

  initial begin
    rst_s = 1'b1; rx_rdy_s = 1'b0; rx_d_s = 8'h00; tx_rdy_s = 1'b1;
    rst_l = 1'b1; rx_rdy_l = 1'b0; rx_d_l = 8'h00; tx_rdy_l = 1'b1;

    // Reset values
    @(negedge clk);
    check_eq("rst_we", 32'(we_s), 32'h0);
    check_eq("rst_tx_en", 32'(tx_en_s), 32'h0);
    check_eq("rst_waddr", 32'(waddr_s), 32'h0);
    check_eq("rst_wdata", 32'(wdata_s), 32'h0);
    check_eq("rst_tx_data", 32'(tx_d_s), 32'h0);
    check_eq("rst_l_tx_en", 32'(tx_en_l), 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_s = 1'b0; rst_l = 1'b0;
    repeat (5) @(posedge clk);

    // Dummy byte after reset: exactly one strobe cycle, data 0x00, no writes
    check_eq("init_tx_cnt", 32'(s_tx_q.size()), 32'd1);
    check_eq("init_tx_data", 32'(s_tx_q[0]), 32'h00);
    check_eq("init_no_we", 32'(s_addr_q.size()), 32'd0);
    check_eq("init_l_tx_cnt", 32'(l_tx_cnt), 32'd1);

    // Basic 4-byte load with write latency check
    send_s(8'h77); send_s(8'h01); pulse_s(8'h02);
    @(negedge clk);
    check_eq("we_latency", 32'(we_s), 32'h1);
    @(negedge clk);
    check_eq("we_one_cycle", 32'(we_s), 32'h0);
    send_s(8'h03); send_s(8'h04);
    repeat (8) @(posedge clk);
    check_eq("load1_we_cnt", 32'(s_addr_q.size()), 32'd2);
    check_eq("load1_addr0", 32'(s_addr_q[0]), 32'd0);
    check_eq("load1_data0", 32'(s_data_q[0]), 32'h0201);
    check_eq("load1_addr1", 32'(s_addr_q[1]), 32'd1);
    check_eq("load1_data1", 32'(s_data_q[1]), 32'h0403);
    check_eq("load1_tx_cnt", 32'(s_tx_q.size()), 32'd2);
    check_eq("load1_ack", 32'(s_tx_q[1]), 32'h0A);

    // Non-command bytes ignored; ack held until the transmitter is idle
    send_s(8'h73); send_s(8'h00); send_s(8'hFF);
    repeat (5) @(posedge clk);
    check_eq("junk_no_we", 32'(s_addr_q.size()), 32'd2);
    check_eq("junk_no_tx", 32'(s_tx_q.size()), 32'd2);
    tx_rdy_s = 1'b0;
    send_s(8'h77); send_s(8'h10); send_s(8'h20); send_s(8'h30); send_s(8'h40);
    repeat (10) @(posedge clk);
    check_eq("busy_ack_held", 32'(s_tx_q.size()), 32'd2);
    check_eq("load2_we_cnt", 32'(s_addr_q.size()), 32'd4);
    check_eq("load2_addr0", 32'(s_addr_q[2]), 32'd0);
    check_eq("load2_data0", 32'(s_data_q[2]), 32'h2010);
    check_eq("load2_addr1", 32'(s_addr_q[3]), 32'd1);
    check_eq("load2_data1", 32'(s_data_q[3]), 32'h4030);
    #1 tx_rdy_s = 1'b1;
    repeat (5) @(posedge clk);
    check_eq("load2_tx_cnt", 32'(s_tx_q.size()), 32'd3);
    check_eq("load2_ack", 32'(s_tx_q[2]), 32'hA0);

    // Reset after 'w' and three data bytes
    send_s(8'h77); send_s(8'hAA); send_s(8'hBB); send_s(8'hCC);
    repeat (2) @(posedge clk);
    check_eq("part_we_cnt", 32'(s_addr_q.size()), 32'd5);
    check_eq("part_addr0", 32'(s_addr_q[4]), 32'd0);
    check_eq("part_data0", 32'(s_data_q[4]), 32'hBBAA);
    @(posedge clk); #1;
    rst_s = 1'b1;
    #1;
    check_eq("midrst_we", 32'(we_s), 32'h0);
    check_eq("midrst_tx_en", 32'(tx_en_s), 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_s = 1'b0;
    repeat (4) @(posedge clk);
    check_eq("midrst_dummy_cnt", 32'(s_tx_q.size()), 32'd4);
    check_eq("midrst_dummy_data", 32'(s_tx_q[3]), 32'h00);
    send_s(8'h77); send_s(8'h01); send_s(8'h02); send_s(8'h03); send_s(8'h04);
    repeat (8) @(posedge clk);
    check_eq("reload_we_cnt", 32'(s_addr_q.size()), 32'd7);
    check_eq("reload_addr0", 32'(s_addr_q[5]), 32'd0);
    check_eq("reload_data0", 32'(s_data_q[5]), 32'h0201);
    check_eq("reload_addr1", 32'(s_addr_q[6]), 32'd1);
    check_eq("reload_data1", 32'(s_data_q[6]), 32'h0403);
    check_eq("reload_ack", 32'(s_tx_q[4]), 32'h0A);

`ifdef LOADER_TIMEOUT_EN
    // Silence after one data byte produces a NAK and no write
    send_s(8'h77); send_s(8'h55);
    repeat (85) @(posedge clk);
    check_eq("tmo_not_early", 32'(s_tx_q.size()), 32'd5);
    repeat (35) @(posedge clk);
    check_eq("tmo_tx_cnt", 32'(s_tx_q.size()), 32'd6);
    check_eq("tmo_nak", 32'(s_tx_q[5]), 32'hEE);
    check_eq("tmo_no_we", 32'(s_addr_q.size()), 32'd7);
    send_s(8'h77); send_s(8'h01); send_s(8'h02); send_s(8'h03); send_s(8'h04);
    repeat (8) @(posedge clk);
    check_eq("post_tmo_we_cnt", 32'(s_addr_q.size()), 32'd9);
    check_eq("post_tmo_addr0", 32'(s_addr_q[7]), 32'd0);
    check_eq("post_tmo_ack", 32'(s_tx_q[6]), 32'h0A);
`endif

    // Full-size load of 0xFF bytes
    send_l(8'h77);
    for (int i = 0; i < 16384; i++) send_l(8'hFF);
    repeat (10) @(posedge clk);
    check_eq("full_we_cnt", 32'(l_we_cnt), 32'd8192);
    check_eq("full_tx_cnt", 32'(l_tx_cnt), 32'd2);
    check_eq("full_ack", 32'(l_tx_last), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
